apb_master_arbiter: RTL and testbench
=====================================

// Module: apb_master_arbiter
// PURPOSE
// - Shares one APB3 master port between NUM_REQ local requesters (timer config, debug, DMA).
// - Round-robin arbitration; sequences APB IDLE->SETUP->ACCESS per granted transfer.
// - Returns read data and error status to the winner. Aborts slaves stalled beyond TIMEOUT cycles.
// PARAMETERS
// - NUM_REQ  = 4  : number of requesters, 2..8
// - ADDR_W   = 12 : APB address width
// - DATA_W   = 32 : APB data width
// - TIMEOUT  = 16 : max ACCESS cycles waiting on PREADY; 0 disables the timeout
// PORTS
// - PCLK       in   1                 APB clock; all logic on posedge
// - PRESETn    in   1                 reset, asynchronous assert, active-low
// - req_i      in   NUM_REQ           per-requester request; hold until done_o[i]
// - req_wr_i   in   NUM_REQ           1=write, 0=read
// - req_addr_i in   NUM_REQ*ADDR_W    packed addresses, requester i at [i*ADDR_W +: ADDR_W]
// - req_wdata_i in  NUM_REQ*DATA_W    packed write data
// - done_o     out  NUM_REQ           1-cycle pulse: transfer for requester i completed
// - rdata_o    out  DATA_W            read data, valid while any done_o bit is high
// - err_o      out  1                 valid with done_o: PSLVERR or timeout
// - PSEL, PENABLE, PWRITE  out 1      APB control
// - PADDR      out  ADDR_W            APB address
// - PWDATA     out  DATA_W            APB write data
// - PRDATA     in   DATA_W            APB read data
// - PREADY     in   1                 slave ready
// - PSLVERR    in   1                 slave error
// BEHAVIOUR
// - Reset (PRESETn=0, async): state=IDLE.
//   - PSEL=PENABLE=PWRITE=0, PADDR=0, PWDATA=0.
//   - done_o=0, rdata_o=0, err_o=0, rr pointer=0, timeout counter=0.
// - States:
//   - IDLE: PSEL=0.
//   - SETUP: PSEL=1, PENABLE=0.
//   - ACCESS: PSEL=1, PENABLE=1.
// - IDLE -> SETUP when |req_i. Winner is the first set bit at or after rr pointer, wrapping modulo NUM_REQ.
//   - The winner's wr/addr/wdata are registered into PWRITE/PADDR/PWDATA on the same edge.
// - SETUP -> ACCESS unconditionally (1 cycle). PADDR/PWRITE/PWDATA stay stable through SETUP and ACCESS.
// - ACCESS, PREADY=1: transfer completes.
//   - done_o[winner]=1 next cycle; rdata_o<=PRDATA (reads only, else hold); err_o<=PSLVERR.
//   - rr pointer <= winner+1 mod NUM_REQ.
//   - Next state is SETUP if a request other than the winner's is pending (back-to-back, no IDLE bubble), else IDLE.
//   - The winner's own req_i is masked in the completion cycle, so its next transfer is not re-issued before done_o is seen.
// - ACCESS, PREADY=0: stay in ACCESS; timeout counter increments.
//   - If TIMEOUT!=0 and the counter reaches TIMEOUT-1 with PREADY still 0: abort, with done_o[winner]=1, err_o=1, rdata_o unchanged.
//   - Exit to IDLE with PSEL=PENABLE=0. Counter clears on every entry to SETUP.
// - Minimum latency: req_i rise to done_o is 3 cycles (SETUP, ACCESS w/ PREADY, done).
// - Requests that deassert before grant are ignored. Deasserting after grant does not cancel the transfer.
// - Simultaneous requests: only one grant. The others wait; worst-case wait is NUM_REQ-1 transfers.
// - Reset mid-transfer drops PSEL/PENABLE immediately (async). No done_o is issued for the aborted transfer.
// - Illegal state encoding returns to IDLE.
// STRUCTURE
// - apb_pkg:
//   - apb_state_t enum {IDLE=2'b00, SETUP=2'b01, ACCESS=2'b10}, shared with the existing APB FSM.
//   - Localparams for APB widths.
// - Sub-module rr_arbiter #(N): inputs req, ptr, en; outputs one-hot gnt and binary idx.
//   - Combinational; the pointer register lives in the parent.
// - Parent holds: FSM, grant index register, APB output registers, timeout counter ($clog2(TIMEOUT+1) bits).
// TESTING
// - Single write: req_i=0001, wr=1, addr=0x010, wdata=0xA5A5_0001, PREADY=1.
//   -> PSEL at cycle 1, PENABLE at cycle 2, done_o=0001 at cycle 3, err_o=0.
// - All four requesters request together, PREADY=1.
//   -> grant order 0,1,2,3; PSEL held high across all 4 transfers with no IDLE gap; 4 done pulses.
// - Read with PREADY low for 3 cycles, PRDATA=0xDEAD_BEEF.
//   -> ACCESS lasts 4 cycles; rdata_o=0xDEAD_BEEF with done_o; PADDR stable throughout.
// - PSLVERR=1 on completion of requester 2 -> done_o=0100, err_o=1.
// - TIMEOUT=16 with PREADY stuck at 0 -> after 16 ACCESS cycles: done_o pulse, err_o=1, PSEL=0.
// - PRESETn pulsed low in ACCESS -> PSEL/PENABLE=0 asynchronously, no done_o, rr pointer=0.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB types and default widths.
// Used by the APB master arbiter and the existing APB FSM.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } apb_state_t;

    localparam int APB_ADDR_W  = 12;
    localparam int APB_DATA_W  = 32;
    localparam int APB_NUM_REQ = 4;
    localparam int APB_TIMEOUT = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first request at or after ptr.
// The pointer register lives in the parent.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    input  logic                 en,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] idx
);

    localparam int IW = $clog2(N);

    int            j;
    logic [IW-1:0] jj;

    // Scan offsets high to low so the smallest offset from ptr wins.
    always_comb begin
        gnt = '0;
        idx = '0;
        j   = 0;
        jj  = '0;
        if (en) begin
            for (int k = N - 1; k >= 0; k--) begin
                j  = (int'(ptr) + k) % N;
                jj = IW'(j);
                if (req[jj]) begin
                    gnt = N'(1) << jj;
                    idx = jj;
                end
            end
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one APB3 master port between NUM_REQ requesters with
// round-robin arbitration and an ACCESS-phase stall timeout.
module apb_master_arbiter
    import apb_pkg::*;
#(
    parameter int NUM_REQ = APB_NUM_REQ,
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = APB_TIMEOUT
) (
    input  logic                      PCLK,
    input  logic                      PRESETn,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ-1:0]        req_wr_i,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
    output logic [NUM_REQ-1:0]        done_o,
    output logic [DATA_W-1:0]         rdata_o,
    output logic                      err_o,
    output logic                      PSEL,
    output logic                      PENABLE,
    output logic                      PWRITE,
    output logic [ADDR_W-1:0]         PADDR,
    output logic [DATA_W-1:0]         PWDATA,
    input  logic [DATA_W-1:0]         PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [IW-1:0] IDX_MAX  = IW'(NUM_REQ - 1);

    apb_state_t          state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [IW-1:0]       ptr_q, ptr_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;

    logic [ADDR_W-1:0]   addr_a  [NUM_REQ];
    logic [DATA_W-1:0]   wdata_a [NUM_REQ];

    logic [NUM_REQ-1:0]  cur_oh, arb_req, arb_gnt;
    logic [IW-1:0]       arb_ptr, arb_idx, ptr_inc;
    logic                arb_en, xfer_ok, timed_out, load;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_a[g]  = req_addr_i[g*ADDR_W +: ADDR_W];
        assign wdata_a[g] = req_wdata_i[g*DATA_W +: DATA_W];
    end

    assign cur_oh    = NUM_REQ'(1) << idx_q;
    assign ptr_inc   = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    assign xfer_ok   = (state_q == ACCESS) && PREADY;
    assign timed_out = (TIMEOUT != 0) && (state_q == ACCESS)
                    && !PREADY && (cnt_q == CNT_LAST);

    // On completion the winner is masked and the search starts after it,
    // so a back-to-back grant always goes to somebody else.
    assign arb_en  = (state_q == IDLE) || xfer_ok;
    assign arb_req = xfer_ok ? (req_i & ~cur_oh) : req_i;
    assign arb_ptr = xfer_ok ? ptr_inc : ptr_q;
    assign load    = |arb_gnt;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req (arb_req),
        .ptr (arb_ptr),
        .en  (arb_en),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        pwrite_d = pwrite_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        done_d   = '0;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            IDLE: ;
            SETUP: state_d = ACCESS;
            ACCESS: begin
                if (xfer_ok) begin
                    done_d  = cur_oh;
                    err_d   = PSLVERR;
                    ptr_d   = ptr_inc;
                    state_d = IDLE;
                    if (!pwrite_q) rdata_d = PRDATA;
                end else if (timed_out) begin
                    done_d  = cur_oh;
                    err_d   = 1'b1;
                    ptr_d   = ptr_inc;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            state_d  = SETUP;
            idx_d    = arb_idx;
            cnt_d    = '0;
            pwrite_d = req_wr_i[arb_idx];
            paddr_d  = addr_a[arb_idx];
            pwdata_d = wdata_a[arb_idx];
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            ptr_q    <= '0;
            cnt_q    <= '0;
            pwrite_q <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            done_q   <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            pwrite_q <= pwrite_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            done_q   <= done_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign PSEL    = (state_q == SETUP) || (state_q == ACCESS);
    assign PENABLE = (state_q == ACCESS);
    assign PWRITE  = pwrite_q;
    assign PADDR   = paddr_q;
    assign PWDATA  = pwdata_q;
    assign done_o  = done_q;
    assign rdata_o = rdata_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Bench for apb_master_arbiter: directed vectors, corner sequences
// and a randomized run against a transfer-level reference model.
module tb_apb_master_arbiter;

    localparam int N  = 4;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          PCLK = 1'b0;
    logic          PRESETn = 1'b0;
    logic [N-1:0]  req = '0;
    logic [N-1:0]  req_wr;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]  done;
    logic [DW-1:0] rdata;
    logic          err;
    logic          PSEL, PENABLE, PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA;
    logic [DW-1:0] PRDATA = '0;
    logic          PREADY = 1'b0;
    logic          PSLVERR = 1'b0;

    logic          t_wr    [N];
    logic [AW-1:0] t_addr  [N];
    logic [DW-1:0] t_wdata [N];

    int checks = 0;
    int errors = 0;

    always #5 PCLK = ~PCLK;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign req_wr[g]              = t_wr[g];
        assign req_addr[g*AW +: AW]   = t_addr[g];
        assign req_wdata[g*DW +: DW]  = t_wdata[g];
    end

    apb_master_arbiter #(
        .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)
    ) dut (
        .PCLK        (PCLK),
        .PRESETn     (PRESETn),
        .req_i       (req),
        .req_wr_i    (req_wr),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .done_o      (done),
        .rdata_o     (rdata),
        .err_o       (err),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PADDR       (PADDR),
        .PWDATA      (PWDATA),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR)
    );

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h @%0t", nm, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic set_txn(input logic [1:0] i, input logic wr,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        t_wr[i]    = wr;
        t_addr[i]  = a;
        t_wdata[i] = d;
    endtask

    task automatic do_reset();
        PRESETn = 1'b0;
        req     = '0;
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        @(posedge PCLK);
        #1;
        chk("rst_psel", 64'(PSEL), 64'd0);
        chk("rst_penable", 64'(PENABLE), 64'd0);
        chk("rst_pwrite", 64'(PWRITE), 64'd0);
        chk("rst_paddr", 64'(PADDR), 64'd0);
        chk("rst_pwdata", 64'(PWDATA), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_rdata", 64'(rdata), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        PRESETn = 1'b1;
    endtask

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++)
            if (v[2'((p + k) % N)]) return (p + k) % N;
        return -1;
    endfunction

    typedef struct {
        logic [N-1:0]  req;
        logic          pready;
        logic          pslverr;
        logic          psel;
        logic          pen;
        logic [N-1:0]  done;
        logic          err;
        logic          pwrite;
        logic [AW-1:0] paddr;
        logic [DW-1:0] rdata;
    } vec_t;

    vec_t tbl [8];

    // Random-phase reference state
    logic [N-1:0]  pend;
    logic [N-1:0]  exp_done;
    logic          exp_err;
    logic [DW-1:0] m_rdata;
    int            age, win, mptr, wait_n;

    task automatic start_from(input logic [N-1:0] v);
        if (v != '0) begin
            win    = pick(v, mptr);
            age    = 0;
            wait_n = ($urandom % 10 == 0) ? 1000 : int'($urandom % 4);
        end else begin
            age = -1;
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) set_txn(2'(i), 1'b0, '0, '0);

        // ---------------- directed table ----------------
        do_reset();
        set_txn(2'd0, 1'b1, 12'h010, 32'hA5A5_0001);
        set_txn(2'd2, 1'b0, 12'h0C8, 32'h0);
        PRDATA = 32'h1234_5678;
        tbl[0] = '{4'b0001, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 12'h010, 32'h0};
        tbl[1] = '{4'b0001, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b1, 12'h010, 32'h0};
        tbl[2] = '{4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b0, 12'h000, 32'h0};
        tbl[3] = '{4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 12'h000, 32'h0};
        tbl[4] = '{4'b0100, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 12'h0C8, 32'h0};
        tbl[5] = '{4'b0100, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 12'h0C8, 32'h0};
        tbl[6] = '{4'b0100, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0100, 1'b1, 1'b0, 12'h000, 32'h1234_5678};
        tbl[7] = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 12'h000, 32'h1234_5678};
        for (int r = 0; r < 8; r++) begin
            req     = tbl[r].req;
            PREADY  = tbl[r].pready;
            PSLVERR = tbl[r].pslverr;
            step();
            chk($sformatf("tbl%0d_psel", r), 64'(PSEL), 64'(tbl[r].psel));
            chk($sformatf("tbl%0d_pen", r), 64'(PENABLE), 64'(tbl[r].pen));
            chk($sformatf("tbl%0d_done", r), 64'(done), 64'(tbl[r].done));
            chk($sformatf("tbl%0d_rdata", r), 64'(rdata), 64'(tbl[r].rdata));
            if (tbl[r].done != '0)
                chk($sformatf("tbl%0d_err", r), 64'(err), 64'(tbl[r].err));
            if (tbl[r].psel) begin
                chk($sformatf("tbl%0d_paddr", r), 64'(PADDR), 64'(tbl[r].paddr));
                chk($sformatf("tbl%0d_pwrite", r), 64'(PWRITE), 64'(tbl[r].pwrite));
            end
        end

        // ------- reset in ACCESS (pointer is 3 here) -------
        set_txn(2'd1, 1'b0, 12'h333, 32'h0);
        req    = 4'b0010;
        PREADY = 1'b0;
        step();
        step();
        step();
        chk("mid_pen_before", 64'(PENABLE), 64'd1);
        #2;
        PRESETn = 1'b0;
        #1;
        chk("mid_psel_async", 64'(PSEL), 64'd0);
        chk("mid_pen_async", 64'(PENABLE), 64'd0);
        req = '0;
        @(posedge PCLK);
        #1;
        PRESETn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("mid_no_done", 64'(done), 64'd0);
        end
        set_txn(2'd0, 1'b1, 12'h0A0, 32'h1);
        set_txn(2'd3, 1'b1, 12'hFA0, 32'h2);
        req    = 4'b1001;
        PREADY = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            step();
            if (n == 1) chk("mid_ptr0_paddr", 64'(PADDR), 64'h0A0);
            if (n == 3) chk("mid_done0", 64'(done), 64'b0001);
            if (n == 3) chk("mid_b2b_paddr", 64'(PADDR), 64'hFA0);
            if (n == 5) chk("mid_done3", 64'(done), 64'b1000);
            if (n == 3) req = 4'b1000;
            if (n == 5) req = 4'b0000;
        end

        // ---------- all four at once ----------
        do_reset();
        for (int i = 0; i < N; i++)
            set_txn(2'(i), 1'b1, 12'(32'h100 + i), 32'hC0DE_0000 + i);
        req     = 4'b1111;
        PREADY  = 1'b1;
        PSLVERR = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            logic [N-1:0] dn;
            step();
            dn = (c >= 3 && c <= 9 && c % 2 == 1) ? 4'(1 << ((c - 3) / 2)) : 4'b0;
            chk($sformatf("all4_psel_c%0d", c), 64'(PSEL), 64'(c <= 8));
            chk($sformatf("all4_done_c%0d", c), 64'(done), 64'(dn));
            if (c <= 8 && c % 2 == 1)
                chk($sformatf("all4_order_c%0d", c), 64'(PADDR),
                    64'(32'h100 + (c - 1) / 2));
            req = req & ~dn;
        end

        // ---------- read with 3 wait states ----------
        set_txn(2'd1, 1'b0, 12'h2A4, 32'h0);
        req = 4'b0010;
        for (int c = 0; c < 7; c++) begin
            int n;
            PREADY = (c == 5);
            PRDATA = (c == 5) ? 32'hDEAD_BEEF : 32'h0BAD_0000 + c;
            step();
            n = c + 1;
            chk($sformatf("wait_psel_c%0d", n), 64'(PSEL), 64'(n >= 1 && n <= 5));
            chk($sformatf("wait_pen_c%0d", n), 64'(PENABLE), 64'(n >= 2 && n <= 5));
            chk($sformatf("wait_done_c%0d", n), 64'(done), (n == 6) ? 64'b0010 : 64'd0);
            if (PSEL) chk($sformatf("wait_paddr_c%0d", n), 64'(PADDR), 64'h2A4);
            if (n == 6) begin
                chk("wait_rdata", 64'(rdata), 64'hDEAD_BEEF);
                chk("wait_err", 64'(err), 64'd0);
                req = '0;
            end
        end

        // ---------- timeout ----------
        set_txn(2'd3, 1'b1, 12'hFFC, 32'h5555_AAAA);
        req    = 4'b1000;
        PREADY = 1'b0;
        for (int c = 0; c < 19; c++) begin
            int n;
            step();
            n = c + 1;
            chk($sformatf("to_psel_c%0d", n), 64'(PSEL), 64'(n >= 1 && n <= 17));
            chk($sformatf("to_pen_c%0d", n), 64'(PENABLE), 64'(n >= 2 && n <= 17));
            chk($sformatf("to_done_c%0d", n), 64'(done), (n == 18) ? 64'b1000 : 64'd0);
            if (n == 18) begin
                chk("to_err", 64'(err), 64'd1);
                chk("to_rdata_hold", 64'(rdata), 64'hDEAD_BEEF);
                req = '0;
            end
        end

        // ---------- randomized run vs transfer model ----------
        do_reset();
        pend    = '0;
        mptr    = 0;
        age     = -1;
        win     = 0;
        wait_n  = 0;
        m_rdata = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            req     = pend;
            PRDATA  = $urandom;
            PSLVERR = ($urandom % 4 == 0);
            PREADY  = (age >= 1) ? (age - 1 >= wait_n) : 1'($urandom % 2);
            exp_done = '0;
            exp_err  = 1'b0;
            if (age >= 1 && PREADY) begin
                exp_done = 4'(1 << win);
                exp_err  = PSLVERR;
                if (!t_wr[2'(win)]) m_rdata = PRDATA;
                mptr = (win + 1) % N;
                start_from(req & ~4'(1 << win));
            end else if (age >= 1 && age == TO) begin
                exp_done = 4'(1 << win);
                exp_err  = 1'b1;
                mptr     = (win + 1) % N;
                age      = -1;
            end else if (age >= 0) begin
                age++;
            end else begin
                start_from(req);
            end
            step();
            chk("r_psel", 64'(PSEL), 64'(age >= 0));
            chk("r_penable", 64'(PENABLE), 64'(age >= 1));
            chk("r_done", 64'(done), 64'(exp_done));
            chk("r_rdata", 64'(rdata), 64'(m_rdata));
            if (exp_done != '0) chk("r_err", 64'(err), 64'(exp_err));
            if (age >= 0) begin
                chk("r_paddr", 64'(PADDR), 64'(t_addr[2'(win)]));
                chk("r_pwrite", 64'(PWRITE), 64'(t_wr[2'(win)]));
                chk("r_pwdata", 64'(PWDATA), 64'(t_wdata[2'(win)]));
            end
            for (int i = 0; i < N; i++) begin
                if (exp_done[2'(i)]) begin
                    pend[2'(i)] = 1'b0;
                end else if (!pend[2'(i)] && $urandom % 3 == 0) begin
                    set_txn(2'(i), 1'($urandom % 2), 12'($urandom), $urandom);
                    pend[2'(i)] = 1'b1;
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
